// File: rtl/mux2_pipe_if.sv
// Stream bundle for mux2_pipe: two producer streams, a select, and one consumer stream.
// The slave modport is the selector's view; the master modport is the producers' and consumer's view.
interface mux2_pipe_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b;
    logic             b_valid;
    logic             b_ready;
    logic             s;
    logic [WIDTH-1:0] o_comb;
    logic [WIDTH-1:0] o;
    logic             o_src;
    logic             o_valid;
    logic             o_ready;

    modport slave (
        input  a, a_valid, b, b_valid, s, o_ready,
        output a_ready, b_ready, o_comb, o, o_src, o_valid
    );

    modport master (
        output a, a_valid, b, b_valid, s, o_ready,
        input  a_ready, b_ready, o_comb, o, o_src, o_valid
    );
endinterface

// File: rtl/mux2_pipe.sv
// 2:1 stream selector with a combinational tap and a 2-entry skid buffer.
// The buffer is a head register (drives o) plus one skid register behind it.
module mux2_pipe #(
    parameter int WIDTH = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    mux2_pipe_if.slave  bus
);
    logic [WIDTH-1:0] r_head_data;
    logic             r_head_src;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_src;
    logic [1:0]       r_count;

    logic             w_ready;
    logic             w_sel_valid;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_push;
    logic             w_pop;

    assign bus.o_comb = bus.s ? bus.b : bus.a;

    // Ready depends only on registered occupancy (and reset), never on o_ready.
    assign w_ready     = rst_n && (r_count < 2'd2);
    assign bus.a_ready = w_ready & ~bus.s;
    assign bus.b_ready = w_ready &  bus.s;

    assign w_sel_valid = bus.s ? bus.b_valid : bus.a_valid;
    assign w_sel_data  = bus.s ? bus.b : bus.a;
    assign w_push      = w_sel_valid & w_ready;
    assign w_pop       = (r_count != 2'd0) & bus.o_ready;

    assign bus.o_valid = (r_count != 2'd0);
    assign bus.o       = r_head_data;
    assign bus.o_src   = r_head_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_data <= '0;
            r_head_src  <= 1'b0;
            r_skid_data <= '0;
            r_skid_src  <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head_data <= w_sel_data;
                        r_head_src  <= bus.s;
                    end else begin
                        r_skid_data <= w_sel_data;
                        r_skid_src  <= bus.s;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    // Popping the last beat leaves the head untouched so o holds.
                    if (r_count == 2'd2) begin
                        r_head_data <= r_skid_data;
                        r_head_src  <= r_skid_src;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head_data <= w_sel_data;
                        r_head_src  <= bus.s;
                    end else begin
                        r_head_data <= r_skid_data;
                        r_head_src  <= r_skid_src;
                        r_skid_data <= w_sel_data;
                        r_skid_src  <= bus.s;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mux2_pipe.sv
// Scoreboard bench for mux2_pipe: accepted beats are queued as {src,data}
// and compared against the head whenever the consumer pops.
module tb_mux2_pipe;
    localparam int WIDTH = 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [WIDTH:0]   sb_q[$];
    int               m_count;
    logic [WIDTH-1:0] last_o;
    logic             last_src;

    mux2_pipe_if #(.WIDTH(WIDTH)) bus ();

    mux2_pipe #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_count  = 0;
        last_o   = '0;
        last_src = 1'b0;
    endtask

    // Inputs are already driven; check readies, predict the edge, advance, check the head.
    task automatic step();
        logic exp_ready, sel_valid, do_push, do_pop;
        logic [WIDTH-1:0] sel_data;
        #1;
        exp_ready = (m_count < 2);
        check("a_ready", bus.a_ready, exp_ready & ~bus.s);
        check("b_ready", bus.b_ready, exp_ready &  bus.s);
        sel_valid = bus.s ? bus.b_valid : bus.a_valid;
        sel_data  = bus.s ? bus.b : bus.a;
        do_push = sel_valid & exp_ready;
        do_pop  = (m_count > 0) & bus.o_ready;
        if (do_pop) begin
            check("pop_data", bus.o, sb_q[0][WIDTH-1:0]);
            check("pop_src", bus.o_src, sb_q[0][WIDTH]);
            void'(sb_q.pop_front());
            m_count--;
        end
        if (do_push) begin
            sb_q.push_back({bus.s, sel_data});
            m_count++;
        end
        @(posedge clk);
        #1;
        check("o_valid", bus.o_valid, (m_count > 0));
        if (m_count > 0) begin
            last_o   = sb_q[0][WIDTH-1:0];
            last_src = sb_q[0][WIDTH];
        end
        check("o", bus.o, last_o);
        check("o_src", bus.o_src, last_src);
    endtask

    task automatic drive(input logic s, input logic av, input logic a,
                         input logic bv, input logic b, input logic ordy);
        bus.s = s; bus.a_valid = av; bus.a = a;
        bus.b_valid = bv; bus.b = b; bus.o_ready = ordy;
    endtask

    initial begin
        logic [2:0] combo;
        logic [7:0] comb_exp;
        checks = 0;
        errors = 0;
        model_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        // Truth table applied while reset is held: o_comb must still work.
        comb_exp = 8'b1101_1000; // bit i = expected o_comb for (a,b,s)=i
        for (int i = 0; i < 8; i++) begin
            combo = i[2:0];
            bus.a = combo[2]; bus.b = combo[1]; bus.s = combo[0];
            #10;
            check("o_comb", bus.o_comb, comb_exp[i]);
        end
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        #1;
        check("rst_a_ready", bus.a_ready, 1'b0);
        check("rst_b_ready", bus.b_ready, 1'b0);
        check("rst_o_valid", bus.o_valid, 1'b0);
        check("rst_o", bus.o, 1'b0);
        check("rst_o_src", bus.o_src, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: a single A beat into an empty buffer.
        drive(0, 1, 1, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0, 1); step();
        step();

        // Backpressure: two B beats fill the buffer, third is refused, then drain.
        drive(1, 0, 0, 1, 1, 0); step();
        drive(1, 0, 0, 1, 0, 0); step();
        drive(1, 0, 0, 1, 1, 0); step();
        drive(1, 0, 0, 0, 0, 1); step(); step(); step();

        // Select isolation: B valid while A is selected is ignored.
        drive(0, 0, 0, 1, 1, 0); step(); step();
        drive(1, 0, 0, 1, 1, 0); step();
        drive(1, 0, 0, 0, 0, 1); step(); step();

        // Select switch with a full buffer.
        drive(0, 1, 1, 0, 0, 0); step();
        drive(1, 0, 0, 1, 0, 0); step();
        drive(1, 0, 0, 0, 0, 1); step(); step(); step();

        // Reset mid-operation with two beats buffered.
        drive(0, 1, 1, 0, 0, 0); step();
        drive(0, 1, 0, 0, 0, 0); step();
        rst_n = 1'b0;
        #2;
        check("mid_rst_o_valid", bus.o_valid, 1'b0);
        check("mid_rst_o", bus.o, 1'b0);
        check("mid_rst_a_ready", bus.a_ready, 1'b0);
        check("mid_rst_b_ready", bus.b_ready, 1'b0);
        model_reset();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("post_rst_a_ready", bus.a_ready, 1'b1);
        check("post_rst_b_ready", bus.b_ready, 1'b0);
        step();

        // Random traffic with arbitrary select changes.
        for (int n = 0; n < 300; n++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) != 0));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
